// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - DMG timer/divider peripheral (DIV, TIMA, TMA, TAC at $FF04-$FF07)
module gb_timer #(
   parameter logic [15:0] DIV_INIT  = 16'h0000,
   parameter int          OVF_DELAY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ADDR,
   input  logic        WR,
   input  logic        RD,
   input  logic [7:0]  MMIO_DATA_out,
   output logic [7:0]  MMIO_DATA_in,
   output logic        IRQ_TIMER
);

   localparam logic [2:0] OVF_LAST = 3'(OVF_DELAY);

   logic [15:0] sys_cnt;
   logic [7:0]  tima;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic [2:0]  ovf_cnt;
   logic        tin_d;

   logic sel_bit;
   logic tin;
   logic tick;
   logic reload;
   logic wr_div;
   logic wr_tima;
   logic wr_tma;
   logic wr_tac;
   logic unused_rd;

   // Reads are purely address-decoded, so the read strobe carries no information here.
   assign unused_rd = RD;

   always_comb begin
      sel_bit = sys_cnt[9];
      case (tac[1:0])
         2'b00:   sel_bit = sys_cnt[9];
         2'b01:   sel_bit = sys_cnt[3];
         2'b10:   sel_bit = sys_cnt[5];
         default: sel_bit = sys_cnt[7];
      endcase
   end

   // Falling-edge detect on the gated tap: DIV writes and TAC changes can tick TIMA too.
   assign tin    = tac[2] & sel_bit;
   assign tick   = tin_d & ~tin;
   assign reload = (ovf_cnt == OVF_LAST);

   assign wr_div  = WR && (ADDR == 16'hFF04);
   assign wr_tima = WR && (ADDR == 16'hFF05);
   assign wr_tma  = WR && (ADDR == 16'hFF06);
   assign wr_tac  = WR && (ADDR == 16'hFF07);

   always_ff @(posedge clk) begin
      if (rst) begin
         sys_cnt <= DIV_INIT;
         tima    <= 8'h00;
         tma     <= 8'h00;
         tac     <= 3'b000;
         ovf_cnt <= 3'd0;
         tin_d   <= 1'b0;
      end else begin
         tin_d   <= tin;
         sys_cnt <= wr_div ? 16'h0000 : sys_cnt + 16'd1;
         if (wr_tma) begin
            tma <= MMIO_DATA_out;
         end
         if (wr_tac) begin
            tac <= MMIO_DATA_out[2:0];
         end
         // Reload clk beats a TIMA write and any tick; a TMA write lands straight in TIMA.
         if (reload) begin
            tima    <= wr_tma ? MMIO_DATA_out : tma;
            ovf_cnt <= 3'd0;
         end else if (wr_tima) begin
            tima    <= MMIO_DATA_out;
            ovf_cnt <= 3'd0;
         end else begin
            if (ovf_cnt != 3'd0) begin
               ovf_cnt <= ovf_cnt + 3'd1;
            end
            if (tick) begin
               if (tima == 8'hFF) begin
                  tima    <= 8'h00;
                  ovf_cnt <= 3'd1;
               end else begin
                  tima <= tima + 8'd1;
               end
            end
         end
      end
   end

   assign IRQ_TIMER = reload & ~rst;

   always_comb begin
      MMIO_DATA_in = 8'hFF;
      case (ADDR)
         16'hFF04: MMIO_DATA_in = sys_cnt[15:8];
         16'hFF05: MMIO_DATA_in = (ovf_cnt != 3'd0) ? 8'h00 : tima;
         16'hFF06: MMIO_DATA_in = tma;
         16'hFF07: MMIO_DATA_in = {5'b11111, tac};
         default:  MMIO_DATA_in = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_gb_timer.sv
// tb/tb_gb_timer.sv - randomized and directed bench for gb_timer against a behavioural model
module tb_gb_timer;

   localparam logic [15:0] DIV_INIT  = 16'h0000;
   localparam int          OVF_DELAY = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ADDR;
   logic        WR;
   logic        RD;
   logic [7:0]  MMIO_DATA_out;
   logic [7:0]  MMIO_DATA_in;
   logic        IRQ_TIMER;

   gb_timer #(.DIV_INIT(DIV_INIT), .OVF_DELAY(OVF_DELAY)) dut (
      .clk(clk),
      .rst(rst),
      .ADDR(ADDR),
      .WR(WR),
      .RD(RD),
      .MMIO_DATA_out(MMIO_DATA_out),
      .MMIO_DATA_in(MMIO_DATA_in),
      .IRQ_TIMER(IRQ_TIMER)
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_errors = 0;
   int     irq_cnt  = 0;
   logic [7:0] last_rd;
   logic       last_irq;

   // Reference state: absolute cycle of the pending reload instead of a delay counter.
   int     m_cnt;
   int     m_tima;
   int     m_tma;
   int     m_tac;
   bit     m_prev_in;
   longint m_reload_at;
   longint cyc = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %02h expected %02h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic bit m_in();
      int b;
      case (m_tac & 3)
         0:       b = 9;
         1:       b = 3;
         2:       b = 5;
         default: b = 7;
      endcase
      return (((m_tac >> 2) & 1) != 0) && (((m_cnt >> b) & 1) != 0);
   endfunction

   function automatic int m_read(input logic [15:0] a);
      case (a)
         16'hFF04: return (m_cnt >> 8) & 255;
         16'hFF05: return (m_reload_at >= 0) ? 0 : m_tima;
         16'hFF06: return m_tma;
         16'hFF07: return 'hF8 | m_tac;
         default:  return 'hFF;
      endcase
   endfunction

   task automatic model_step(input bit r, input logic [15:0] a, input bit w, input logic [7:0] d);
      bit in_now;
      bit tick;
      if (r) begin
         m_cnt = int'(DIV_INIT); m_tima = 0; m_tma = 0; m_tac = 0;
         m_prev_in = 0; m_reload_at = -1;
      end else begin
         in_now = m_in();
         tick   = m_prev_in && !in_now;
         if (m_reload_at == cyc) begin
            m_tima = (w && a == 16'hFF06) ? int'(d) : m_tma;
            m_reload_at = -1;
         end else if (w && a == 16'hFF05) begin
            m_tima = int'(d);
            m_reload_at = -1;
         end else if (tick) begin
            if (m_tima == 255) begin
               m_tima = 0;
               m_reload_at = cyc + OVF_DELAY;
            end else begin
               m_tima = m_tima + 1;
            end
         end
         m_prev_in = in_now;
         m_cnt = (w && a == 16'hFF04) ? 0 : (m_cnt + 1) % 65536;
         if (w && a == 16'hFF06) m_tma = int'(d);
         if (w && a == 16'hFF07) m_tac = int'(d) & 7;
      end
      cyc++;
   endtask

   task automatic step(input bit r, input logic [15:0] a, input bit w, input logic [7:0] d);
      rst = r; ADDR = a; WR = w; RD = !w; MMIO_DATA_out = d;
      #1;
      last_rd  = MMIO_DATA_in;
      last_irq = IRQ_TIMER;
      check("irq", {7'b0, last_irq}, {7'b0, (!r && m_reload_at == cyc)});
      check("rd", last_rd, 8'(m_read(a)));
      if (last_irq) irq_cnt++;
      model_step(r, a, w, d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic [15:0] a);
      step(1'b0, a, 1'b0, 8'h00);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      step(1'b0, a, 1'b1, d);
   endtask

   task automatic arm();
      wr(16'hFF06, 8'hF0);
      wr(16'hFF05, 8'hFF);
      wr(16'hFF07, 8'h05);
   endtask

   // Leaves the bench just after the first clk that reads TIMA as 00 (delay clk 1).
   task automatic wait_ovf(input string tag);
      int n = 0;
      do begin
         idle(16'hFF05);
         n++;
      end while (last_rd != 8'h00 && n < 64);
      check(tag, last_rd, 8'h00);
   endtask

   initial begin
      rst = 1'b1; ADDR = 16'h0000; WR = 1'b0; RD = 1'b0; MMIO_DATA_out = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_step(1'b1, 16'h0000, 1'b0, 8'h00);

      // 1: first tick 16 clk after enabling the 262144 Hz source
      wr(16'hFF07, 8'h05);
      repeat (16) idle(16'hFF05);
      check("t1_pre", last_rd, 8'h00);
      idle(16'hFF05);
      check("t1_first", last_rd, 8'h01);
      repeat (16) idle(16'hFF05);
      check("t1_second", last_rd, 8'h02);

      // 2: overflow, reload from TMA, single IRQ clk
      irq_cnt = 0;
      arm();
      wait_ovf("t2_ovf");
      repeat (2) idle(16'hFF05);
      check("t2_hold", last_rd, 8'h00);
      idle(16'hFF05);
      check("t2_irq", {7'b0, last_irq}, 8'h01);
      idle(16'hFF05);
      check("t2_reload", last_rd, 8'hF0);
      check("t2_irq_once", 8'(irq_cnt), 8'd1);

      // 3a: TIMA write at delay clk 2 cancels the reload
      arm();
      wait_ovf("t3a_ovf");
      wr(16'hFF05, 8'h42);
      irq_cnt = 0;
      repeat (6) idle(16'hFF05);
      check("t3a_tima", last_rd, 8'h42);
      check("t3a_noirq", 8'(irq_cnt), 8'd0);

      // 3b: TIMA write in the reload clk is ignored
      arm();
      wait_ovf("t3b_ovf");
      repeat (2) idle(16'hFF05);
      wr(16'hFF05, 8'h99);
      check("t3b_irq", {7'b0, last_irq}, 8'h01);
      idle(16'hFF05);
      check("t3b_tima", last_rd, 8'hF0);

      // 3c: TMA write in the reload clk goes straight into TIMA
      arm();
      wait_ovf("t3c_ovf");
      repeat (2) idle(16'hFF05);
      wr(16'hFF06, 8'h77);
      idle(16'hFF05);
      check("t3c_tima", last_rd, 8'h77);

      // 4: DIV write while the 4096 Hz tap is high ticks TIMA
      begin
         int n = 0;
         wr(16'hFF07, 8'h04);
         do begin
            idle(16'hFF04);
            n++;
         end while (last_rd[1] != 1'b1 && n < 2048);
         check("t4_bit9", {7'b0, last_rd[1]}, 8'h01);
      end
      wr(16'hFF05, 8'h10);
      wr(16'hFF04, 8'h5A);
      idle(16'hFF04);
      check("t4_div", last_rd, 8'h00);
      idle(16'hFF05);
      check("t4_quirk", last_rd, 8'h11);

      // 5: DIV free-runs and wraps after 65536 clk
      step(1'b1, 16'hFF04, 1'b0, 8'h00);
      for (int i = 0; i <= 65536; i++) begin
         idle(16'hFF04);
         if (i == 0) check("t5_start", last_rd, 8'h00);
         if (i == 65535) check("t5_top", last_rd, 8'hFF);
         if (i == 65536) check("t5_wrap", last_rd, 8'h00);
      end

      // 6: reset during the overflow delay
      arm();
      wait_ovf("t6_ovf");
      irq_cnt = 0;
      step(1'b1, 16'hFF05, 1'b0, 8'h00);
      idle(16'hFF04);
      check("t6_div", last_rd, 8'h00);
      idle(16'hFF07);
      check("t6_tac", last_rd, 8'hF8);
      idle(16'hFF06);
      check("t6_tma", last_rd, 8'h00);
      idle(16'hFF05);
      check("t6_tima", last_rd, 8'h00);
      idle(16'hFF03);
      check("t6_ff03", last_rd, 8'hFF);
      idle(16'hFF08);
      check("t6_ff08", last_rd, 8'hFF);
      repeat (4) idle(16'hFF05);
      check("t6_noirq", 8'(irq_cnt), 8'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a;
         logic [7:0]  d;
         bit          w;
         bit          r;
         a = 16'hFF03 + 16'($urandom_range(0, 5));
         w = ($urandom_range(0, 5) == 0);
         d = 8'($urandom);
         if (w && a == 16'hFF04 && $urandom_range(0, 3) != 0) a = 16'hFF05;
         if (w && a == 16'hFF05 && $urandom_range(0, 1) == 0) d = d | 8'hF8;
         r = ($urandom_range(0, 999) == 0);
         step(r, a, w, d);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
